bt_cmd_ctrl: RTL and testbench

Command controller between the UART byte receiver and the camera-side control logic. It takes the receiver's byte strobe and frames 4-byte command packets: header, opcode, argument, checksum. It validates each packet and queues accepted commands in a small FIFO. Commands are delivered over a valid/ready handshake so a slower consumer can drain them, for example the SCCB register writer or the capture/display mode sequencer.

---
 rtl/bt_cmd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bt_cmd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bt_cmd_ctrl
// Purpose  : Frames 4-byte UART command packets (hdr, op, arg, sum), validates
//            them and queues accepted commands for a valid/ready consumer.
//            Optional inter-byte timeout: define BT_CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bt_cmd_ctrl #(
  parameter int         TIMEOUT = 2000000,
  parameter int         FIFO_AW = 2,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_arg,
  input  logic       cmd_ready,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int         C_DEPTH     = 1 << FIFO_AW;
  localparam logic [1:0] C_ERR_SUM   = 2'd1;
  localparam logic [1:0] C_ERR_TO    = 2'd2;
  localparam logic [1:0] C_ERR_OVF   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_ARG  = 2'd2,
    S_SUM  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_op;
  logic [7:0]         r_arg;
  logic [7:0]         w_sum;
  logic               w_sum_ok;
  logic               w_sum_bad;
  logic               w_timeout;

  logic               r_push_pend;
  logic [15:0]        r_push_data;
  logic [15:0]        r_mem [C_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_pop;
  logic               w_full;
  logic               w_do_push;
  logic               w_ovf;

  logic               r_err;
  logic [1:0]         r_err_code;

  assign w_sum = HEADER + r_op + r_arg;

  always_comb begin
    w_state_nxt = r_state;
    w_sum_ok    = 1'b0;
    w_sum_bad   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE:  if (rx_data == HEADER) w_state_nxt = S_OP;
        S_OP:    w_state_nxt = S_ARG;
        S_ARG:   w_state_nxt = S_SUM;
        S_SUM: begin
          w_state_nxt = S_IDLE;
          if (rx_data == w_sum) w_sum_ok  = 1'b1;
          else                  w_sum_bad = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 8'd0;
      r_arg       <= 8'd0;
      r_push_pend <= 1'b0;
      r_push_data <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      if (rx_valid && (r_state == S_OP))  r_op  <= rx_data;
      if (rx_valid && (r_state == S_ARG)) r_arg <= rx_data;
      // FIFO write is deferred one edge so the checksum compare stays off the write path
      r_push_pend <= w_sum_ok;
      r_push_data <= {r_op, r_arg};
    end
  end

`ifdef BT_CMD_TIMEOUT_EN
  localparam int            C_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(TIMEOUT - 1);

  logic [C_TW-1:0] r_idle_cnt;

  assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_idle_cnt == C_TO_LAST);

  always_ff @(posedge clk) begin
    if (rst || rx_valid || w_timeout || (r_state == S_IDLE)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  // Parser waits forever; TIMEOUT has no effect in this build.
  assign w_timeout = (TIMEOUT < 0);
`endif

  assign w_pop     = (r_count != '0) && cmd_ready;
  assign w_full    = (r_count == C_DEPTH[FIFO_AW:0]);
  assign w_do_push = r_push_pend && (!w_full || w_pop);
  assign w_ovf     = r_push_pend && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= 16'd0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= r_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_err <= w_sum_bad | w_ovf | w_timeout;
      if (w_ovf)           r_err_code <= C_ERR_OVF;
      else if (w_sum_bad)  r_err_code <= C_ERR_SUM;
      else if (w_timeout)  r_err_code <= C_ERR_TO;
    end
  end

  assign cmd_valid = (r_count != '0);
  assign cmd_op    = r_mem[r_rd_ptr][15:8];
  assign cmd_arg   = r_mem[r_rd_ptr][7:0];
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bt_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bt_cmd_ctrl
// Purpose  : Randomized bench for bt_cmd_ctrl with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bt_cmd_ctrl;

  localparam int         TO    = 100;
  localparam int         AW    = 2;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] HDR   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  bt_cmd_ctrl #(.TIMEOUT(TO), .FIFO_AW(AW), .HEADER(HDR)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_ready (cmd_ready),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte position within a frame, a queue for the FIFO,
  // and one pending push that lands on the edge after the checksum byte.
  logic [15:0] mq[$];
  int          m_idx  = 0;
  int          m_sil  = 0;
  logic [7:0]  m_op   = 8'd0;
  logic [7:0]  m_arg  = 8'd0;
  bit          m_pend = 1'b0;
  logic [15:0] m_pdata = 16'd0;
  bit          m_err  = 1'b0;
  logic [1:0]  m_code = 2'd0;

  always @(posedge clk) begin
    bit pop;
    bit e;
    if (rst) begin
      mq.delete();
      m_idx  = 0;
      m_sil  = 0;
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_code = 2'd0;
    end else begin
      e   = 1'b0;
      pop = (mq.size() > 0) && cmd_ready;
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pdata);
        else begin
          e      = 1'b1;
          m_code = 2'd3;
        end
        m_pend = 1'b0;
      end
      if (rx_valid) begin
        m_sil = 0;
        case (m_idx)
          0: if (rx_data == HDR) m_idx = 1;
          1: begin m_op  = rx_data; m_idx = 2; end
          2: begin m_arg = rx_data; m_idx = 3; end
          default: begin
            m_idx = 0;
            if (rx_data == 8'(HDR + m_op + m_arg)) begin
              m_pend  = 1'b1;
              m_pdata = {m_op, m_arg};
            end else begin
              e      = 1'b1;
              m_code = 2'd1;
            end
          end
        endcase
      end else if (m_idx != 0) begin
`ifdef BT_CMD_TIMEOUT_EN
        m_sil++;
        if (m_sil == TO) begin
          m_idx  = 0;
          m_sil  = 0;
          e      = 1'b1;
          m_code = 2'd2;
        end
`endif
      end
      m_err = e;
    end
  end

  task automatic check_outputs();
    chk("cmd_valid", cmd_valid, mq.size() > 0);
    if (mq.size() > 0) chk("cmd_head", {cmd_op, cmd_arg}, mq[0]);
    chk("busy", busy, m_idx != 0);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] arg, input bit good);
    logic [7:0] s;
    s = HDR + op + arg;
    if (!good) s = s + 8'($urandom_range(1, 255));
    send(HDR);
    send(op);
    send(arg);
    send(s);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_op"}, cmd_op, 0);
    chk({tag, "_arg"}, cmd_arg, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_code"}, err_code, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int r;
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'd0;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Good frame, consumer always ready
    cmd_ready = 1'b1;
    frame(8'h10, 8'h22, 1'b1);
    idle(3);
    chk("good_code", err_code, 0);

    // Bad checksum, then a good frame
    send(HDR); send(8'h10); send(8'h22); send(8'h00);
    idle(2);
    chk("bad_code", err_code, 1);
    frame(8'h33, 8'h44, 1'b1);
    idle(3);

    // Garbage ahead of a frame
    send(8'h00); send(8'hFF); send(8'h5A);
    chk("garbage_busy", busy, 0);
    send(HDR); send(8'h01); send(8'h02); send(8'hA8);
    idle(3);

    // Overflow: five frames into a four-deep queue
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) frame(8'(i + 1), 8'(8'h10 + i), 1'b1);
    idle(2);
    chk("ovf_code", err_code, 3);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", {cmd_op, cmd_arg}, {8'(i + 1), 8'(8'h10 + i)});
      tick();
    end
    chk("ovf_drained", cmd_valid, 0);

    // Silence mid-frame
    send(HDR); send(8'h10);
    idle(TO + 5);
`ifdef BT_CMD_TIMEOUT_EN
    chk("to_code", err_code, 2);
    chk("to_busy", busy, 0);
    frame(8'h55, 8'h66, 1'b1);
`else
    chk("to_code", err_code, 3);
    chk("to_busy", busy, 1);
    send(8'h22); send(8'hD7);
`endif
    idle(3);

    // Reset mid-frame with two queued commands
    cmd_ready = 1'b0;
    frame(8'h71, 8'h72, 1'b1);
    frame(8'h73, 8'h74, 1'b1);
    send(HDR); send(8'h10);
    idle(1);
    chk("pre_rst_valid", cmd_valid, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    cmd_ready = 1'b1;
    frame(8'h0C, 8'h0D, 1'b1);
    idle(1);
    chk("post_rst_one", {cmd_valid, cmd_op, cmd_arg}, {1'b1, 8'h0C, 8'h0D});
    tick();
    chk("post_rst_empty", cmd_valid, 0);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    repeat (250) begin
      r = $urandom_range(0, 99);
      if (r < 65)      frame(8'($urandom), 8'($urandom), 1'b1);
      else if (r < 85) frame(8'($urandom), 8'($urandom), 1'b0);
      else if (r < 95) send(8'($urandom));
      else begin
        send(HDR);
        repeat ($urandom_range(0, 2)) send(8'($urandom));
        idle(TO + 3);
      end
      idle($urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    cmd_ready  = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
